// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the I/D requesters, the shared memory port and mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if;
  logic        IReq;
  logic [63:0] IAddr;
  logic        IReady;
  logic [31:0] IRdata;
  logic        DReq;
  logic        DWr;
  logic [63:0] DAddr;
  logic [63:0] DWdata;
  logic        DReady;
  logic [63:0] DRdata;
  logic [63:0] MemAddr;
  logic [63:0] MemWdata;
  logic        MemWr;
  logic [63:0] MemRdata;
  logic        Busy;
  logic        Owner;

  modport slave (
    input  IReq, IAddr, DReq, DWr, DAddr, DWdata, MemRdata,
    output IReady, IRdata, DReady, DRdata, MemAddr, MemWdata, MemWr, Busy, Owner
  );

  modport master (
    output IReq, IAddr, DReq, DWr, DAddr, DWdata, MemRdata,
    input  IReady, IRdata, DReady, DRdata, MemAddr, MemWdata, MemWr, Busy, Owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch (I) and load/store (D).
// IDLE grants round-robin, ACCESS counts the memory latency, RESP pulses the ready.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [CW-1:0] r_cnt;
  logic        r_owner;
  logic        r_last;
  logic        r_wr;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_drdata;
  logic [31:0] r_irdata;

  logic        w_any;
  logic        w_gnt_d;
  logic        w_gnt_wr;
  logic        w_last_beat;

  assign w_any       = bus.IReq | bus.DReq;
  // On conflict the port that did not own the last grant wins.
  assign w_gnt_d     = bus.DReq & (~bus.IReq | ~r_last);
  assign w_gnt_wr    = w_gnt_d & bus.DWr;
  assign w_last_beat = (r_state == S_ACCESS) && (r_cnt == CW'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_ACCESS;
      S_ACCESS: if (w_last_beat) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt    <= '0;
      r_owner  <= 1'b0;
      r_last   <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_drdata <= '0;
      r_irdata <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_any) begin
        r_owner <= w_gnt_d;
        r_last  <= w_gnt_d;
        r_wr    <= w_gnt_wr;
        r_addr  <= w_gnt_d ? bus.DAddr : bus.IAddr;
        r_wdata <= w_gnt_d ? bus.DWdata : '0;
        r_cnt   <= w_gnt_wr ? CW'(1) : CW'(MEM_LAT);
      end
      if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt - CW'(1);
        if (w_last_beat && !r_wr) begin
          if (r_owner) begin
            r_drdata <= bus.MemRdata;
          end else begin
            r_irdata <= bus.MemRdata[31:0];
          end
        end
      end
    end
  end

  // Writes load a count of 1, so ACCESS of a write is a single cycle and the strobe is that cycle.
  assign bus.MemWr    = (r_state == S_ACCESS) && r_wr;
  assign bus.IReady   = (r_state == S_RESP) && !r_owner;
  assign bus.DReady   = (r_state == S_RESP) && r_owner;
  assign bus.Busy     = (r_state != S_IDLE);
  assign bus.Owner    = r_owner;
  assign bus.MemAddr  = r_addr;
  assign bus.MemWdata = r_wdata;
  assign bus.IRdata   = r_irdata;
  assign bus.DRdata   = r_drdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios on MEM_LAT=1 and 3 instances
// plus a randomized two-requester run checked against a transaction-level timing model.
module tb_mem_port_arbiter;

  localparam int unsigned LAT1 = 1;
  localparam int unsigned LAT3 = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  mem_port_arbiter_if if1();
  mem_port_arbiter_if if3();

  mem_port_arbiter #(.MEM_LAT(LAT1)) dut1 (.Clk(Clk), .Reset(Reset), .bus(if1));
  mem_port_arbiter #(.MEM_LAT(LAT3)) dut3 (.Clk(Clk), .Reset(Reset), .bus(if3));

  always #5 Clk = ~Clk;

  function automatic logic [63:0] mem_init(int unsigned i);
    if (i == 2) return 64'h0000_0000_00A0_0093;
    return {32'hC0DE_0000 + i, 32'h1000_0000 + i * 7};
  endfunction

  logic [63:0] mem1 [16];
  logic [63:0] mem3 [16];
  logic [63:0] p3a, p3b;

  assign if1.MemRdata = mem1[if1.MemAddr[6:3]];
  assign if3.MemRdata = p3b;

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) mem1[i] <= mem_init(i);
    end else if (if1.MemWr) begin
      mem1[if1.MemAddr[6:3]] <= if1.MemWdata;
    end
  end

  // Latency-3 memory: two register stages after the address is presented.
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) mem3[i] <= mem_init(i);
      p3a <= '0;
      p3b <= '0;
    end else begin
      if (if3.MemWr) mem3[if3.MemAddr[6:3]] <= if3.MemWdata;
      p3a <= mem3[if3.MemAddr[6:3]];
      p3b <= p3a;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    if1.IReq = 0; if1.IAddr = '0; if1.DReq = 0; if1.DWr = 0; if1.DAddr = '0; if1.DWdata = '0;
    if3.IReq = 0; if3.IAddr = '0; if3.DReq = 0; if3.DWr = 0; if3.DAddr = '0; if3.DWdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    next_cycle();
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = '0;
    a[6:3] = 4'($urandom_range(0, 15));
    return a;
  endfunction

  task automatic test_reset();
    clear_inputs();
    Reset = 1'b1;
    #2;
    n_cmp++;
    if ({if1.IReady, if1.DReady, if1.MemWr, if1.Busy, if1.Owner, if1.MemAddr, if1.MemWdata,
         if1.IRdata, if1.DRdata} !== '0) begin
      n_bad++; $display("FAIL reset_dut1 got busy=%0b owner=%0b addr=%h exp all zero", if1.Busy, if1.Owner, if1.MemAddr);
    end
    n_cmp++;
    if ({if3.IReady, if3.DReady, if3.MemWr, if3.Busy, if3.Owner, if3.MemAddr, if3.MemWdata,
         if3.IRdata, if3.DRdata} !== '0) begin
      n_bad++; $display("FAIL reset_dut3 got busy=%0b owner=%0b addr=%h exp all zero", if3.Busy, if3.Owner, if3.MemAddr);
    end
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    next_cycle();
    @(negedge Clk);
    n_cmp++;
    if ({if1.IReady, if1.DReady, if1.MemWr, if1.Busy} !== 4'b0) begin
      n_bad++; $display("FAIL reset_release got rdyI/rdyD/wr/busy=%b exp 0000", {if1.IReady, if1.DReady, if1.MemWr, if1.Busy});
    end
    next_cycle();
  endtask

  task automatic test_read_lat1();
    if1.IReq = 1; if1.IAddr = 64'h10;
    @(negedge Clk);
    n_cmp++;
    if (if1.Busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_t got=%0b exp=0", if1.Busy); end
    next_cycle(); @(negedge Clk);
    n_cmp++;
    if (if1.MemAddr !== 64'h10) begin n_bad++; $display("FAIL rd_memaddr got=%h exp=10", if1.MemAddr); end
    n_cmp++;
    if ({if1.Busy, if1.IReady} !== 2'b10) begin n_bad++; $display("FAIL rd_t1 busy/iready got=%b exp=10", {if1.Busy, if1.IReady}); end
    next_cycle(); @(negedge Clk);
    n_cmp++;
    if ({if1.Busy, if1.IReady, if1.DReady} !== 3'b110) begin
      n_bad++; $display("FAIL rd_t2 busy/iready/dready got=%b exp=110", {if1.Busy, if1.IReady, if1.DReady});
    end
    n_cmp++;
    if (if1.IRdata !== 32'h00A00093) begin n_bad++; $display("FAIL rd_irdata got=%h exp=00a00093", if1.IRdata); end
    next_cycle();
    if1.IReq = 0;
    @(negedge Clk);
    n_cmp++;
    if ({if1.Busy, if1.IReady} !== 2'b00) begin n_bad++; $display("FAIL rd_t3 busy/iready got=%b exp=00", {if1.Busy, if1.IReady}); end
    next_cycle();
  endtask

  task automatic test_write();
    if1.DReq = 1; if1.DWr = 1; if1.DAddr = 64'h20; if1.DWdata = 64'hDEADBEEF_01234567;
    next_cycle(); @(negedge Clk);
    n_cmp++;
    if ({if1.MemWr, if1.DReady, if1.Owner} !== 3'b101) begin
      n_bad++; $display("FAIL wr_t1 memwr/dready/owner got=%b exp=101", {if1.MemWr, if1.DReady, if1.Owner});
    end
    n_cmp++;
    if (if1.MemAddr !== 64'h20 || if1.MemWdata !== 64'hDEADBEEF_01234567) begin
      n_bad++; $display("FAIL wr_bus got addr=%h data=%h exp 20/deadbeef01234567", if1.MemAddr, if1.MemWdata);
    end
    next_cycle(); @(negedge Clk);
    n_cmp++;
    if ({if1.MemWr, if1.DReady, if1.IReady} !== 3'b010) begin
      n_bad++; $display("FAIL wr_t2 memwr/dready/iready got=%b exp=010", {if1.MemWr, if1.DReady, if1.IReady});
    end
    n_cmp++;
    if (if1.DRdata !== 64'h0) begin n_bad++; $display("FAIL wr_drdata got=%h exp=0", if1.DRdata); end
    next_cycle();
    if1.DReq = 0; if1.DWr = 0;
    @(negedge Clk);
    n_cmp++;
    if (mem1[4] !== 64'hDEADBEEF_01234567) begin n_bad++; $display("FAIL wr_mem got=%h exp=deadbeef01234567", mem1[4]); end
    next_cycle();
  endtask

  task automatic test_conflict();
    logic [63:0] w6, w3;
    logic [31:0] w3lo;
    w6 = mem_init(6);
    w3 = mem_init(3);
    w3lo = w3[31:0];
    do_reset();
    if1.IReq = 1; if1.IAddr = 64'h18;
    if1.DReq = 1; if1.DWr = 0; if1.DAddr = 64'h30;
    next_cycle(); @(negedge Clk);
    n_cmp++;
    if (if1.Owner !== 1'b1 || if1.MemAddr !== 64'h30) begin
      n_bad++; $display("FAIL cf_first owner=%0b addr=%h exp 1/30", if1.Owner, if1.MemAddr);
    end
    next_cycle(); @(negedge Clk);
    n_cmp++;
    if ({if1.DReady, if1.IReady} !== 2'b10) begin n_bad++; $display("FAIL cf_dready got d/i=%b exp=10", {if1.DReady, if1.IReady}); end
    n_cmp++;
    if (if1.DRdata !== w6) begin n_bad++; $display("FAIL cf_drdata got=%h exp=%h", if1.DRdata, w6); end
    next_cycle();
    if1.DReq = 0;
    @(negedge Clk);
    n_cmp++;
    if ({if1.Busy, if1.IReady, if1.DReady} !== 3'b000) begin
      n_bad++; $display("FAIL cf_idle busy/i/d got=%b exp=000", {if1.Busy, if1.IReady, if1.DReady});
    end
    next_cycle(); @(negedge Clk);
    n_cmp++;
    if (if1.Owner !== 1'b0 || if1.MemAddr !== 64'h18) begin
      n_bad++; $display("FAIL cf_second owner=%0b addr=%h exp 0/18", if1.Owner, if1.MemAddr);
    end
    next_cycle(); @(negedge Clk);
    n_cmp++;
    if ({if1.IReady, if1.DReady} !== 2'b10 || if1.IRdata !== w3lo) begin
      n_bad++; $display("FAIL cf_iready got i/d=%b irdata=%h exp 10/%h", {if1.IReady, if1.DReady}, if1.IRdata, w3lo);
    end
    next_cycle();
    if1.IReq = 0;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic exp_i, exp_d;
    int k;
    do_reset();
    if1.IReq = 1; if1.IAddr = 64'h08;
    if1.DReq = 1; if1.DWr = 0; if1.DAddr = 64'h28;
    for (int c = 0; c <= 20; c++) begin
      @(negedge Clk);
      exp_i = 1'b0; exp_d = 1'b0;
      if (c >= 2 && (c - 2) % 3 == 0) begin
        k = (c - 2) / 3;
        if (k % 2 == 0) exp_d = 1'b1; else exp_i = 1'b1;
      end
      n_cmp++;
      if ({if1.IReady, if1.DReady} !== {exp_i, exp_d}) begin
        n_bad++; $display("FAIL b2b_c%0d got i/d=%b exp=%b", c, {if1.IReady, if1.DReady}, {exp_i, exp_d});
      end
      next_cycle();
      if (c == 19) begin if1.IReq = 0; if1.DReq = 0; end
    end
    next_cycle();
  endtask

  task automatic test_latency3();
    logic [63:0] w8;
    w8 = mem_init(8);
    if3.DReq = 1; if3.DWr = 0; if3.DAddr = 64'h40;
    for (int c = 1; c <= 4; c++) begin
      next_cycle(); @(negedge Clk);
      if (c == 1) begin
        n_cmp++;
        if (if3.MemAddr !== 64'h40) begin n_bad++; $display("FAIL l3_addr got=%h exp=40", if3.MemAddr); end
      end
      n_cmp++;
      if (if3.DReady !== (c == 4)) begin n_bad++; $display("FAIL l3_dready_t%0d got=%0b exp=%0b", c, if3.DReady, (c == 4)); end
    end
    n_cmp++;
    if (if3.DRdata !== w8) begin n_bad++; $display("FAIL l3_drdata got=%h exp=%h", if3.DRdata, w8); end
    next_cycle();
    if3.DWr = 1; if3.DAddr = 64'h48; if3.DWdata = 64'h1122_3344_5566_7788;
    next_cycle(); @(negedge Clk);
    n_cmp++;
    if ({if3.MemWr, if3.DReady} !== 2'b10) begin n_bad++; $display("FAIL l3_wr_t1 memwr/dready got=%b exp=10", {if3.MemWr, if3.DReady}); end
    next_cycle(); @(negedge Clk);
    n_cmp++;
    if ({if3.MemWr, if3.DReady} !== 2'b01) begin n_bad++; $display("FAIL l3_wr_t2 memwr/dready got=%b exp=01", {if3.MemWr, if3.DReady}); end
    next_cycle();
    if3.DReq = 0; if3.DWr = 0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    if1.DReq = 1; if1.DWr = 1; if1.DAddr = 64'h38; if1.DWdata = 64'hABCD_0000_1234_5678;
    next_cycle(); @(negedge Clk);
    n_cmp++;
    if ({if1.MemWr, if1.Busy} !== 2'b11) begin n_bad++; $display("FAIL rm_pre memwr/busy got=%b exp=11", {if1.MemWr, if1.Busy}); end
    #1 Reset = 1'b1;
    #1;
    n_cmp++;
    if ({if1.IReady, if1.DReady, if1.MemWr, if1.Busy, if1.Owner, if1.MemAddr, if1.MemWdata,
         if1.IRdata, if1.DRdata} !== '0) begin
      n_bad++; $display("FAIL rm_async got memwr=%b busy=%b addr=%h wdata=%h exp all zero", if1.MemWr, if1.Busy, if1.MemAddr, if1.MemWdata);
    end
    if1.DReq = 0; if1.DWr = 0;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next_cycle(); @(negedge Clk);
      n_cmp++;
      if ({if1.DReady, if1.Busy} !== 2'b00) begin n_bad++; $display("FAIL rm_quiet_c%0d dready/busy got=%b exp=00", c, {if1.DReady, if1.Busy}); end
    end
    next_cycle();
    if1.IReq = 1; if1.IAddr = 64'h10;
    next_cycle(); next_cycle(); @(negedge Clk);
    n_cmp++;
    if (if1.IReady !== 1'b1 || if1.IRdata !== 32'h00A00093) begin
      n_bad++; $display("FAIL rm_after got iready=%0b irdata=%h exp 1/00a00093", if1.IReady, if1.IRdata);
    end
    next_cycle();
    if1.IReq = 0;
    next_cycle();
  endtask

  task automatic test_random();
    logic [63:0] ref_mem [16];
    int m_gc, m_rc, m_idle_at;
    logic m_own, m_last, m_wr, exp_busy;
    logic [63:0] m_rdata, exp_d;
    logic [31:0] exp_i;
    logic [3:0] m_idx;
    logic seen_i, seen_d;
    do_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = mem_init(i);
    m_gc = -10; m_rc = -10; m_idle_at = 0;
    m_own = 0; m_last = 0; m_wr = 0;
    m_rdata = '0; exp_d = '0; exp_i = '0;
    seen_i = 0; seen_d = 0;
    for (int c = 0; c < 400; c++) begin
      if (if1.IReq) begin
        if (seen_i) begin if1.IReq = 1'($urandom_range(0, 1)); if1.IAddr = rand_addr(); end
      end else if ($urandom_range(0, 2) == 0) begin
        if1.IReq = 1; if1.IAddr = rand_addr();
      end
      if (!if1.DReq || seen_d) begin
        if (if1.DReq) if1.DReq = 1'($urandom_range(0, 1));
        else if1.DReq = ($urandom_range(0, 2) == 0);
        if1.DWr = 1'($urandom_range(0, 1));
        if1.DAddr = rand_addr();
        if1.DWdata = {$urandom, $urandom};
      end
      @(negedge Clk);
      if (c == m_rc && !m_wr) begin
        if (m_own) exp_d = m_rdata; else exp_i = m_rdata[31:0];
      end
      exp_busy = (c > m_gc) && (c <= m_rc);
      n_cmp++;
      if (if1.IReady !== (c == m_rc && !m_own)) begin n_bad++; $display("FAIL rnd_iready c=%0d got=%0b exp=%0b", c, if1.IReady, (c == m_rc && !m_own)); end
      n_cmp++;
      if (if1.DReady !== (c == m_rc && m_own)) begin n_bad++; $display("FAIL rnd_dready c=%0d got=%0b exp=%0b", c, if1.DReady, (c == m_rc && m_own)); end
      n_cmp++;
      if (if1.Busy !== exp_busy) begin n_bad++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, if1.Busy, exp_busy); end
      n_cmp++;
      if (if1.Owner !== m_last) begin n_bad++; $display("FAIL rnd_owner c=%0d got=%0b exp=%0b", c, if1.Owner, m_last); end
      n_cmp++;
      if (if1.IRdata !== exp_i) begin n_bad++; $display("FAIL rnd_irdata c=%0d got=%h exp=%h", c, if1.IRdata, exp_i); end
      n_cmp++;
      if (if1.DRdata !== exp_d) begin n_bad++; $display("FAIL rnd_drdata c=%0d got=%h exp=%h", c, if1.DRdata, exp_d); end
      seen_i = if1.IReady;
      seen_d = if1.DReady;
      if (c >= m_idle_at && (if1.IReq || if1.DReq)) begin
        m_own  = (if1.IReq && if1.DReq) ? ~m_last : if1.DReq;
        m_last = m_own;
        m_gc   = c;
        m_wr   = m_own & if1.DWr;
        m_idx  = m_own ? if1.DAddr[6:3] : if1.IAddr[6:3];
        if (m_wr) ref_mem[m_idx] = if1.DWdata;
        else m_rdata = ref_mem[m_idx];
        m_rc = c + 1 + (m_wr ? 1 : int'(LAT1));
        m_idle_at = m_rc + 1;
      end
      next_cycle();
    end
    clear_inputs();
    next_cycle();
    next_cycle();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_read_lat1();
    test_write();
    test_conflict();
    test_back_to_back();
    test_latency3();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares one 64-bit data-memory port between two requesters of the multicycle core: the instruction-fetch path (I, read-only) and the load/store path (D, read/write). Each request is accepted in an idle cycle, driven to the memory for a fixed number of cycles, and completed with a one-cycle ready pulse and latched read data. Simultaneous requests are resolved round-robin. This allows a single Memoria64-style array to replace separate instruction and data memories.

## Interface
- MEM_LAT, 1: memory read latency in cycles, from the address being presented to MemRdata being valid. Legal values are 1 and above; 0 is illegal.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IReq  in  1  fetch request. Held high, with IAddr stable, until IReady.
- IAddr  in  64  fetch address.
- IReady  out  1  one-cycle completion pulse for the fetch.
- IRdata  out  32  fetched word, MemRdata[31:0]. Held until the next I completion.
- DReq  in  1  data request. Held high, with DWr, DAddr and DWdata stable, until DReady.
- DWr  in  1  1 = write, 0 = read.
- DAddr  in  64  data address.
- DWdata  in  64  write data.
- DReady  out  1  one-cycle completion pulse for the data access.
- DRdata  out  64  load data. Held until the next D read completion; writes leave it unchanged.
- MemAddr  out  64  registered address to the memory.
- MemWdata  out  64  registered write data to the memory.
- MemWr  out  1  memory write strobe.
- MemRdata  in  64  memory read data.
- Busy  out  1  high when the state is not IDLE.
- Owner  out  1  0 = I, 1 = D. Shows the current or most recent grant.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - Requests are sampled only in this state.
  - If exactly one Req is high, that requester is granted.
  - If both are high, the requester other than LastOwner is granted. LastOwner resets to 0, so the first conflict goes to D.
  - On a grant, these are registered: MemAddr, MemWdata (D writes; 0 for I), Owner, LastOwner and the counter. The FSM moves to ACCESS.
  - The counter loads MEM_LAT for reads and 1 for writes.
- ACCESS:
  - MemWr is 1 only in the first ACCESS cycle of a D write; it is 0 at all other times.
  - The counter decrements every cycle.
  - In the cycle where the counter equals 1, a read captures MemRdata into IRdata[31:0] or DRdata, according to Owner. The FSM then moves to RESP.
  - Counter width is $clog2(MEM_LAT+1).
- RESP:
  - IReady or DReady, according to Owner, is 1 for exactly this cycle.
  - The next state is always IDLE.
  - A Req still high in the following IDLE cycle is treated as a new request.
- Requests change no output while the FSM is in ACCESS or RESP.
- IReady and DReady are never high in the same cycle.
- Reset, including mid-access:
  - The state goes to IDLE immediately and the in-flight access is dropped with no ready pulse.
  - MemWr, IReady, DReady, Busy, Owner and LastOwner go to 0.
  - MemAddr, MemWdata, IRdata and DRdata go to 0.

## Timing
- Req is high in IDLE cycle t. The grant takes effect at the end of cycle t, and MemAddr is valid from t+1.
- Read: ACCESS occupies t+1 to t+MEM_LAT, and Ready is high in t+MEM_LAT+1. With MEM_LAT=1, Ready is at t+2.
- Write: MemWr is high in t+1 and Ready is high in t+2, independent of MEM_LAT.
- Minimum spacing between grant cycles:
  - MEM_LAT+2 cycles for reads.
  - 3 cycles for writes.
- A requester that deasserts Req on the edge ending its Ready cycle is not re-granted.
- Under continuous requests from both ports, grants strictly alternate.

## Test plan
- Read latency, MEM_LAT=1, after reset:
  - Stimulus: IReq=1 with IAddr=0x10; the memory returns 0x00000000_00A00093.
  - Required: MemAddr=0x10 at t+1, IReady pulse at t+2, IRdata=0x00A00093, and Busy high for t+1 to t+2.
- D write:
  - Stimulus: DReq=1, DWr=1, DAddr=0x20, DWdata=0xDEADBEEF_01234567.
  - Required: MemWr=1 for exactly t+1, with MemAddr=0x20 and matching MemWdata. DReady at t+2. DRdata unchanged.
- Simultaneous first conflict:
  - Stimulus: IReq and DReq both rise in the same cycle after reset.
  - Required: D is granted first (Owner=1). I is granted in the IDLE cycle after DReady, and IReady follows 3 cycles later.
- Continuous contention:
  - Stimulus: both Req held high for 20 cycles.
  - Required: ready pulses alternate D, I, D, I, with one pulse every 3 cycles. No pulse is ever on both ports in the same cycle.
- Latency parameter:
  - Stimulus: MEM_LAT=3, D read at 0x40 with a memory model of latency 3.
  - Required: DReady at t+4, and DRdata equals the memory word at 0x40.
- Reset mid-access:
  - Stimulus: assert Reset asynchronously during the ACCESS state of a D write.
  - Required: MemWr and Busy drop immediately with no clock edge, no DReady is produced, and all outputs read 0. After Reset is released, a new IReq completes normally.
